// File: rtl/rv32_data_mem_mmio_if.sv
// CPU data-port bundle between the memory stage and the data memory subsystem.
interface rv32_data_mem_mmio_if;
  logic        data_enable;
  logic        data_read;
  logic [31:0] data_addr;
  logic [31:0] data_store;
  logic [31:0] data_fetch;

  modport master (
    output data_enable,
    output data_read,
    output data_addr,
    output data_store,
    input  data_fetch
  );

  modport slave (
    input  data_enable,
    input  data_read,
    input  data_addr,
    input  data_store,
    output data_fetch
  );
endinterface

// File: rtl/rv32_data_mem_mmio.sv
// Data-side memory: word RAM with combinational read plus a peripheral page
// holding a UART transmitter (fed by a small TX FIFO), a cycle counter and a
// programmable baud divisor.
module rv32_data_mem_mmio #(
  parameter int RAM_DEPTH  = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_DIV   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rv32_data_mem_mmio_if.slave    bus,
  output logic                   uart_tx,
  output logic                   tx_busy
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [FW:0] CountFull = (FW+1)'(FIFO_DEPTH);
  localparam logic [15:0] DivReset  = 16'(BAUD_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_t;

  // Storage
  logic [31:0]   r_mem  [RAM_DEPTH];
  logic [7:0]    r_fifo [FIFO_DEPTH];

  // FIFO control
  logic [FW-1:0] r_wrPtr;
  logic [FW-1:0] r_rdPtr;
  logic [FW:0]   r_count;
  logic          r_ovf;

  // Peripheral registers
  logic [31:0]   r_cycle;
  logic [15:0]   r_div;

  // UART transmitter
  uartState_t    r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitCnt;
  logic [15:0]   r_tick;
  logic [15:0]   r_divLatch;
  logic          r_tx;

  // Decode and handshake helpers
  logic          w_wr;
  logic          w_rd;
  logic          w_ramSel;
  logic          w_perSel;
  logic [AW-1:0] w_ramIdx;
  logic [1:0]    w_reg;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pushOk;
  logic          w_pop;
  logic          w_bitEnd;
  logic [15:0]   w_divEff;
  logic [7:0]    w_head;
  logic [31:0]   w_fetch;
  logic          w_unused;

  assign w_wr     = bus.data_enable & ~bus.data_read;
  assign w_rd     = bus.data_enable &  bus.data_read;
  assign w_ramSel = (bus.data_addr[31] == 1'b0) && (bus.data_addr[30:AW+2] == '0);
  assign w_perSel = (bus.data_addr[31:4] == 28'h8000000);
  assign w_ramIdx = bus.data_addr[AW+1:2];
  assign w_reg    = bus.data_addr[3:2];
  assign w_unused = ^bus.data_addr[1:0];

  assign w_full   = (r_count == CountFull);
  assign w_empty  = (r_count == '0);
  assign w_push   = w_wr & w_perSel & (w_reg == 2'd0);
  // Fullness is judged before any same-cycle pop, so a push into a full FIFO
  // is dropped even if the transmitter frees a slot on the same edge.
  assign w_pushOk = w_push & ~w_full;
  assign w_head   = r_fifo[r_rdPtr];

  assign w_divEff = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_bitEnd = (r_tick == (r_divLatch - 16'd1));
  assign w_pop    = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_bitEnd));

  assign uart_tx  = r_tx;
  assign tx_busy  = (r_state != IDLE) | ~w_empty;

  // Combinational read mux: RAM, peripheral registers, or zero.
  always_comb begin
    w_fetch = 32'h0;
    if (w_rd) begin
      if (w_ramSel) begin
        w_fetch = r_mem[w_ramIdx];
      end else if (w_perSel) begin
        case (w_reg)
          2'd1:    w_fetch = {28'h0, r_ovf, w_empty, w_full, (r_state != IDLE)};
          2'd2:    w_fetch = r_cycle;
          2'd3:    w_fetch = {16'h0, r_div};
          default: w_fetch = 32'h0;
        endcase
      end
    end
  end

  assign bus.data_fetch = w_fetch;

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr && w_ramSel) begin
      r_mem[w_ramIdx] <= bus.data_store;
    end
  end

  // FIFO byte storage; only the pointers need reset.
  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_fifo[r_wrPtr] <= bus.data_store[7:0];
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_wr && w_perSel && (w_reg == 2'd1)) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Free-running cycle counter and baud divisor register; writes win over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle <= 32'h0;
      r_div   <= DivReset;
    end else begin
      if (w_wr && w_perSel && (w_reg == 2'd2)) begin
        r_cycle <= 32'h0;
      end else begin
        r_cycle <= r_cycle + 32'd1;
      end
      if (w_wr && w_perSel && (w_reg == 2'd3)) begin
        r_div <= bus.data_store[15:0];
      end
    end
  end

  // 8N1 transmitter; the divisor is latched per frame so mid-frame writes wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= 8'h0;
      r_bitCnt   <= 3'd0;
      r_tick     <= 16'd0;
      r_divLatch <= 16'd1;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state    <= START;
            r_shift    <= w_head;
            r_divLatch <= w_divEff;
            r_tick     <= 16'd0;
            r_tx       <= 1'b0;
          end
        end
        START: begin
          if (w_bitEnd) begin
            r_state  <= DATA;
            r_tx     <= r_shift[0];
            r_shift  <= {1'b0, r_shift[7:1]};
            r_bitCnt <= 3'd0;
            r_tick   <= 16'd0;
          end else begin
            r_tick <= r_tick + 16'd1;
          end
        end
        DATA: begin
          if (w_bitEnd) begin
            r_tick <= 16'd0;
            if (r_bitCnt == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_tx     <= r_shift[0];
              r_shift  <= {1'b0, r_shift[7:1]};
              r_bitCnt <= r_bitCnt + 3'd1;
            end
          end else begin
            r_tick <= r_tick + 16'd1;
          end
        end
        STOP: begin
          if (w_bitEnd) begin
            r_tick <= 16'd0;
            if (!w_empty) begin
              r_state    <= START;
              r_shift    <= w_head;
              r_divLatch <= w_divEff;
              r_tx       <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_tick <= r_tick + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_data_mem_mmio.sv
// Self-checking bench for rv32_data_mem_mmio: RAM, peripheral registers,
// UART framing, FIFO overflow, cycle counter and mid-frame reset.
module tb_rv32_data_mem_mmio;

  localparam logic [31:0] ADDR_TXDATA = 32'h8000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h8000_0004;
  localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0008;
  localparam logic [31:0] ADDR_BAUD   = 32'h8000_000C;

  logic clk;
  logic rst_n;
  logic uart_tx;
  logic tx_busy;

  int testsRun;
  int testsFailed;

  logic [31:0] expQ [$];
  logic        bitQ [$];

  rv32_data_mem_mmio_if bus ();

  rv32_data_mem_mmio #(
    .RAM_DEPTH (1024),
    .FIFO_DEPTH(4),
    .BAUD_DIV  (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .uart_tx(uart_tx),
    .tx_busy(tx_busy)
  );

  // 100 MHz style free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected serial samples (one per clock) for one 8N1 frame.
  function automatic void pushFrame(input logic [7:0] b, input int d);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < d; j++) begin
        bitQ.push_back(frame[i]);
      end
    end
  endfunction

  task automatic busRead(input logic [31:0] addr, output logic [31:0] val);
    @(negedge clk);
    bus.data_enable = 1'b1;
    bus.data_read   = 1'b1;
    bus.data_addr   = addr;
    #1 val = bus.data_fetch;
    #1 bus.data_enable = 1'b0;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.data_enable = 1'b1;
    bus.data_read   = 1'b0;
    bus.data_addr   = addr;
    bus.data_store  = data;
    @(negedge clk);
    bus.data_enable = 1'b0;
    bus.data_read   = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    logic [31:0] exp;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    testsRun++;
    if (uart_tx !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_uart_tx got=%b exp=1", uart_tx);
    end
    testsRun++;
    if (tx_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_tx_busy got=%b exp=0", tx_busy);
    end
    expQ.push_back(32'h0000_0004);
    busRead(ADDR_STATUS, got);
    exp = expQ.pop_front();
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL reset_status got=%h exp=%h", got, exp);
    end
    expQ.push_back(32'd16);
    busRead(ADDR_BAUD, got);
    exp = expQ.pop_front();
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL reset_bauddiv got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_ram();
    logic [31:0] addrs [7];
    logic [31:0] exps  [7];
    logic [31:0] got;
    logic [31:0] exp;
    busWrite(32'h0000_0010, 32'hDEAD_BEEF);
    busWrite(32'h0000_0FFC, 32'h1234_5678);
    busWrite(32'h4000_0000, 32'hCAFE_F00D);
    busWrite(32'h0000_1010, 32'h0BAD_BEEF);
    addrs = '{32'h0000_0010, 32'h0000_0013, 32'h4000_0000, 32'h0000_0FFC,
              32'h0000_1010, ADDR_TXDATA, 32'h8000_0014};
    exps  = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 32'h1234_5678,
              32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 7; i++) expQ.push_back(exps[i]);
    for (int i = 0; i < 7; i++) begin
      busRead(addrs[i], got);
      exp = expQ.pop_front();
      testsRun++;
      if (got !== exp) begin
        testsFailed++;
        $display("[TB] FAIL ram_read[%0d] addr=%h got=%h exp=%h", i, addrs[i], got, exp);
      end
    end
    @(negedge clk);
    bus.data_enable = 1'b1;
    bus.data_read   = 1'b0;
    bus.data_addr   = 32'h0000_0010;
    bus.data_store  = 32'hDEAD_BEEF;
    #1;
    testsRun++;
    if (bus.data_fetch !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL fetch_on_write got=%h exp=00000000", bus.data_fetch);
    end
    @(negedge clk);
    bus.data_enable = 1'b0;
    bus.data_read   = 1'b1;
    #1;
    testsRun++;
    if (bus.data_fetch !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL fetch_idle got=%h exp=00000000", bus.data_fetch);
    end
  endtask

  task automatic test_uart_frame();
    logic got;
    logic exp;
    busWrite(ADDR_BAUD, 32'd4);
    busWrite(ADDR_TXDATA, 32'h0000_00A5);
    testsRun++;
    if (tx_busy !== 1'b1 || uart_tx !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL uart_after_push busy=%b tx=%b exp busy=1 tx=1", tx_busy, uart_tx);
    end
    pushFrame(8'hA5, 4);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      got = uart_tx;
      exp = bitQ.pop_front();
      testsRun++;
      if (got !== exp) begin
        testsFailed++;
        $display("[TB] FAIL uart_a5_sample[%0d] got=%b exp=%b", n, got, exp);
      end
    end
    @(negedge clk);
    testsRun++;
    if (tx_busy !== 1'b0 || uart_tx !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL uart_a5_done busy=%b tx=%b exp busy=0 tx=1", tx_busy, uart_tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [6];
    logic        samples [100];
    logic [31:0] got;
    logic [31:0] exp;
    int          bad;
    bytes = '{8'h3C, 8'hC3, 8'h01, 8'h80, 8'h5A, 8'hFF};
    busWrite(ADDR_BAUD, 32'd2);
    for (int i = 0; i < 5; i++) pushFrame(bytes[i], 2);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          bus.data_enable = 1'b1;
          bus.data_read   = 1'b0;
          bus.data_addr   = ADDR_TXDATA;
          bus.data_store  = {24'h0, bytes[i]};
        end
        @(negedge clk);
        bus.data_enable = 1'b0;
        bus.data_read   = 1'b1;
        expQ.push_back(32'h0000_000B);
        busRead(ADDR_STATUS, got);
        exp = expQ.pop_front();
        testsRun++;
        if (got !== exp) begin
          testsFailed++;
          $display("[TB] FAIL overflow_status got=%h exp=%h", got, exp);
        end
        busWrite(ADDR_STATUS, 32'h0);
        expQ.push_back(32'h0000_0003);
        busRead(ADDR_STATUS, got);
        exp = expQ.pop_front();
        testsRun++;
        if (got !== exp) begin
          testsFailed++;
          $display("[TB] FAIL overflow_clear got=%h exp=%h", got, exp);
        end
      end
      begin
        repeat (2) @(negedge clk);
        for (int n = 0; n < 100; n++) begin
          @(negedge clk);
          samples[n] = uart_tx;
        end
      end
    join
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      logic e;
      e = bitQ.pop_front();
      testsRun++;
      if (samples[n] !== e) begin
        testsFailed++;
        bad++;
        if (bad <= 8) $display("[TB] FAIL b2b_sample[%0d] got=%b exp=%b", n, samples[n], e);
      end
    end
    @(negedge clk);
    testsRun++;
    if (tx_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_busy_end got=%b exp=0", tx_busy);
    end
    expQ.push_back(32'h0000_0004);
    busRead(ADDR_STATUS, got);
    exp = expQ.pop_front();
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL b2b_status_end got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_cycle();
    logic [31:0] got;
    logic [31:0] exp;
    busWrite(ADDR_CYCLE, 32'h1234);
    expQ.push_back(32'd1);
    expQ.push_back(32'd10);
    busRead(ADDR_CYCLE, got);
    exp = expQ.pop_front();
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL cycle_first got=%0d exp=%0d", got, exp);
    end
    repeat (8) @(negedge clk);
    busRead(ADDR_CYCLE, got);
    exp = expQ.pop_front();
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL cycle_ten got=%0d exp=%0d", got, exp);
    end
    @(negedge clk);
    force dut.r_cycle = 32'hFFFF_FFFF;
    #1 release dut.r_cycle;
    expQ.push_back(32'd0);
    expQ.push_back(32'd1);
    busRead(ADDR_CYCLE, got);
    exp = expQ.pop_front();
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL cycle_wrap got=%h exp=%h", got, exp);
    end
    busRead(ADDR_CYCLE, got);
    exp = expQ.pop_front();
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL cycle_after_wrap got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] got;
    logic [31:0] exp;
    int          zeros;
    busWrite(ADDR_BAUD, 32'd4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.data_enable = 1'b1;
      bus.data_read   = 1'b0;
      bus.data_addr   = ADDR_TXDATA;
      bus.data_store  = 32'h0;
    end
    @(negedge clk);
    bus.data_enable = 1'b0;
    bus.data_read   = 1'b1;
    repeat (17) @(negedge clk);
    testsRun++;
    if (uart_tx !== 1'b0 || tx_busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midframe_bit3 tx=%b busy=%b exp tx=0 busy=1", uart_tx, tx_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    testsRun++;
    if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midframe_async_reset tx=%b busy=%b exp tx=1 busy=0", uart_tx, tx_busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expQ.push_back(32'h0000_0004);
    expQ.push_back(32'd16);
    expQ.push_back(32'hDEAD_BEEF);
    busRead(ADDR_STATUS, got);
    exp = expQ.pop_front();
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL midframe_status got=%h exp=%h", got, exp);
    end
    busRead(ADDR_BAUD, got);
    exp = expQ.pop_front();
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL midframe_bauddiv got=%h exp=%h", got, exp);
    end
    busRead(32'h0000_0010, got);
    exp = expQ.pop_front();
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL ram_kept_over_reset got=%h exp=%h", got, exp);
    end
    zeros = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) zeros++;
    end
    testsRun++;
    if (zeros !== 0) begin
      testsFailed++;
      $display("[TB] FAIL midframe_no_more_frames low_samples=%0d exp=0", zeros);
    end
  endtask

  initial begin
    testsRun        = 0;
    testsFailed     = 0;
    rst_n           = 1'b0;
    bus.data_enable = 1'b0;
    bus.data_read   = 1'b1;
    bus.data_addr   = 32'h0;
    bus.data_store  = 32'h0;
    test_reset();
    test_ram();
    test_uart_frame();
    test_back_to_back();
    test_cycle();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/rv32_data_mem_mmio.md
# rv32_data_mem_mmio

Data-side memory subsystem attached directly to the CPU data port (data_enable / data_read / data_addr / data_store / data_fetch), consuming the requests issued by the memory stage. Provides word-wide RAM with combinational read and synchronous write, plus a memory-mapped peripheral page: a UART transmitter fed by a small TX FIFO, a free-running cycle counter and a programmable baud divisor. Read data is returned in the same cycle as the request so the MEM/WB register captures it at the next edge.

## Interface
- RAM_DEPTH, 1024: RAM size in 32-bit words; power of 2.
- FIFO_DEPTH, 4: TX FIFO entries, 8 bits each; power of 2, ≥2.
- BAUD_DIV, 16: reset value of the divisor register, in clocks per UART bit.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- data_enable  input  1  access request this cycle.
- data_read  input  1  1 = read, 0 = write (valid when data_enable=1).
- data_addr  input  32  byte address; bits [1:0] ignored; all accesses are full words.
- data_store  input  32  write data.
- data_fetch  output  32  read data, combinational from address.
- uart_tx  output  1  serial line, 8N1, idle high.
- tx_busy  output  1  1 while the FSM is not IDLE or the FIFO is non-empty.

## Operation
- Decode: RAM when data_addr[31]=0 and data_addr[30:2+log2(RAM_DEPTH)]=0, word index data_addr[log2(RAM_DEPTH)+1:2]. Peripheral page when data_addr[31:4]=0x8000000. Anything else unmapped: reads return 0, writes ignored.
- Write = data_enable & ~data_read; read = data_enable & data_read. data_fetch = 0 when data_enable=0 or write.
- 0x8000_0000 TXDATA: write pushes data_store[7:0] into FIFO; read returns 0.
- 0x8000_0004 STATUS (read): bit0 FSM not IDLE, bit1 FIFO full, bit2 FIFO empty, bit3 sticky overflow, bits[31:4]=0. Any write clears overflow.
- 0x8000_0008 CYCLE: read returns counter; any write loads 0.
- 0x8000_000C BAUDDIV: R/W, bits [15:0]; upper bits read 0. Value 0 treated as 1.
- Push when FIFO full (count evaluated before any same-cycle pop): byte dropped, overflow set. Simultaneous push and pop with FIFO not full: both occur, count unchanged.
- UART FSM states IDLE, START, DATA, STOP. IDLE→START when FIFO non-empty: pop the head byte into the shift register and latch the divisor. START drives 0. DATA sends 8 bits LSB first. STOP drives 1. At STOP end: START if FIFO non-empty (pop again), else IDLE. Each bit lasts D clocks (D = latched divisor), so a frame is 10·D clocks. Divisor writes mid-frame affect only the next frame.
- Cycle counter: 32-bit, +1 every edge, wraps 0xFFFF_FFFF→0. A write takes priority over the increment.

## Timing
- Reset values: uart_tx=1, tx_busy=0, FSM IDLE, FIFO empty, overflow=0, counter=0, divisor=BAUD_DIV. RAM contents are not reset.
- Read latency 0: data_fetch is valid combinationally in the request cycle. RAM/register writes are visible to reads from the next cycle.
- TXDATA write captured at edge E0; FSM pops at E1; uart_tx=0 from E1 until E1+D. Data bit k is driven from E1+(k+1)·D. Stop bit ends at E1+10·D.
- Back-to-back frames have no idle gap.
- tx_busy rises after E0 and falls at the edge that returns the FSM to IDLE with the FIFO empty.
- Reset asserted mid-frame: immediately uart_tx=1, FIFO flushed, FSM IDLE. Partial frame is lost.
- CYCLE write at edge E: read in cycle after E returns 0, then 1, 2, …

## Test plan
- Reset release, read 0x8000_0004 → 0x0000_0004; read 0x8000_000C → 16; uart_tx=1; tx_busy=0.
- Write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 and 0x0000_0013 → 0xDEADBEEF both; read 0x4000_0000 → 0.
- BAUDDIV=4, write TXDATA=0xA5 → uart_tx sequence 0,1,0,1,0,0,1,0,1,1, each 4 clocks, start one edge after the write; tx_busy low after 40 clocks.
- BAUDDIV=2, push 5 bytes in consecutive cycles with FIFO_DEPTH=4 → fifth byte dropped only if FIFO full at that edge (first pop happened, so all 5 accepted); a sixth push immediately after → dropped, STATUS bit3=1; a write to STATUS clears bit3.
- Write CYCLE, read after 10 cycles → 10. Force the counter to 0xFFFF_FFFF via the bench → next value 0.
- Assert rst_n low at mid-frame bit 3 → uart_tx=1 asynchronously, STATUS=0x4 after release, no further frames.
